// File: rtl/serve_sequencer.sv
// Rally sequencer between the referee and the ball/player movement blocks:
// load ball at the serve spot, hold, wait for first touch, play, freeze after a point.
module serve_sequencer #(
  parameter int unsigned TICK_DIV     = 650_000,
  parameter int unsigned HOLD_TICKS   = 150,
  parameter int unsigned FREEZE_TICKS = 50,
  parameter int unsigned SERVE_X1     = 200,
  parameter int unsigned SERVE_X2     = 823,
  parameter int unsigned SERVE_Y      = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        point,
  input  logic        serve_side,
  input  logic        endgame,
  input  logic        first_touch,
  output logic        ball_load,
  output logic [11:0] ball_x_init,
  output logic [11:0] ball_y_init,
  output logic        ball_freeze,
  output logic        players_lock,
  output logic        serve_active,
  output logic [2:0]  dbg_state
);

  localparam int unsigned MAX_TICKS = (HOLD_TICKS > FREEZE_TICKS) ? HOLD_TICKS : FREEZE_TICKS;
  localparam int CW = $clog2(MAX_TICKS + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX   = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] FREEZE_LAST = CW'(FREEZE_TICKS - 1);
  localparam logic [11:0]   X1 = 12'(SERVE_X1);
  localparam logic [11:0]   X2 = 12'(SERVE_X2);

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    HOLD   = 3'd1,
    SERVE  = 3'd2,
    RALLY  = 3'd3,
    FREEZE = 3'd4,
    OVER   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   ball_x_init_q, ball_x_init_d;
  logic          tick;
  logic          timed;

  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    cnt_d         = cnt_q;
    ball_x_init_d = ball_x_init_q;
    tick          = (presc_q == PRESC_MAX);
    timed         = (state_q == HOLD) || (state_q == FREEZE);

    unique case (state_q)
      LOAD:    state_d = HOLD;
      HOLD:    if (tick && cnt_q == HOLD_LAST) state_d = SERVE;
      SERVE:   if (first_touch) state_d = RALLY;
      RALLY:   if (point) state_d = FREEZE;
      FREEZE:  if (tick && cnt_q == FREEZE_LAST) state_d = LOAD;
      OVER:    state_d = OVER;
      default: state_d = LOAD;
    endcase

    if (endgame) state_d = OVER;

    // Timers restart from zero in every state, so each timed state gets its full length.
    if (state_d != state_q || !timed) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      cnt_d   = cnt_q + CW'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end

    // Serve position is captured on entry so it is already valid during the load pulse.
    if (state_d == LOAD && state_q != LOAD) begin
      ball_x_init_d = serve_side ? X2 : X1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LOAD;
      presc_q       <= '0;
      cnt_q         <= '0;
      ball_x_init_q <= X1;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      cnt_q         <= cnt_d;
      ball_x_init_q <= ball_x_init_d;
    end
  end

  // The load pulse is masked while rst is held so the reset LOAD state never fires it early.
  assign ball_load    = (state_q == LOAD) && !rst;
  assign ball_x_init  = ball_x_init_q;
  assign ball_y_init  = 12'(SERVE_Y);
  assign ball_freeze  = (state_q != RALLY);
  assign players_lock = (state_q != SERVE) && (state_q != RALLY);
  assign serve_active = (state_q == SERVE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_serve_sequencer.sv
// Bench for serve_sequencer with a short tick (TICK_DIV=4, HOLD=3 ticks, FREEZE=2 ticks):
// a vector table for the main rally flow plus hand sequences for reset and endgame corners.
module tb_serve_sequencer;

  localparam int W = 31;
  localparam logic [2:0] S_LOAD = 3'd0, S_HOLD = 3'd1, S_SERVE = 3'd2,
                         S_RALLY = 3'd3, S_FREEZE = 3'd4, S_OVER = 3'd5;
  localparam logic [11:0] X1 = 12'd200, X2 = 12'd823, Y0 = 12'd300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        point = 1'b0;
  logic        serve_side = 1'b0;
  logic        endgame = 1'b0;
  logic        first_touch = 1'b0;
  logic        ball_load;
  logic [11:0] ball_x_init;
  logic [11:0] ball_y_init;
  logic        ball_freeze;
  logic        players_lock;
  logic        serve_active;
  logic [2:0]  dbg_state;

  serve_sequencer #(
    .TICK_DIV(4), .HOLD_TICKS(3), .FREEZE_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst), .point(point), .serve_side(serve_side),
    .endgame(endgame), .first_touch(first_touch), .ball_load(ball_load),
    .ball_x_init(ball_x_init), .ball_y_init(ball_y_init), .ball_freeze(ball_freeze),
    .players_lock(players_lock), .serve_active(serve_active), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, point, side, eg, touch;
    logic [2:0]  st;
    logic [11:0] x;
  } vec_t;

  vec_t       vecs[$];
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // Expected outputs for a given state, from the output table of each state.
  function automatic logic [W-1:0] model(input logic [2:0] st, input logic [11:0] x, input logic r);
    logic ld, frz, lck, sa;
    ld  = (st == S_LOAD) && !r;
    frz = (st != S_RALLY);
    lck = (st != S_SERVE) && (st != S_RALLY);
    sa  = (st == S_SERVE);
    return {st, ld, frz, lck, sa, x, Y0};
  endfunction

  task automatic add(input logic r, p, s, e, t, input logic [2:0] st,
                     input logic [11:0] x, input int n);
    vec_t v;
    v.rst = r; v.point = p; v.side = s; v.eg = e; v.touch = t; v.st = st; v.x = x;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Drive inputs for one cycle and check the outputs held during that cycle.
  task automatic step(input logic r, p, s, e, t, input logic [2:0] st,
                      input logic [11:0] x, input string name);
    logic [W-1:0] act, exp;
    @(negedge clk);
    rst = r; point = p; serve_side = s; endgame = e; first_touch = t;
    exp_q.push_back(model(st, x, r));
    #1;
    act = {dbg_state, ball_load, ball_freeze, players_lock, serve_active, ball_x_init, ball_y_init};
    exp = exp_q.pop_front();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got st=%0d load=%b frz=%b lock=%b sa=%b x=%0d y=%0d, expected st=%0d load=%b frz=%b lock=%b sa=%b x=%0d y=%0d",
               name, act[30:28], act[27], act[26], act[25], act[24], act[23:12], act[11:0],
               exp[30:28], exp[27], exp[26], exp[25], exp[24], exp[23:12], exp[11:0]);
    end
  endtask

  // Count clock edges until the given state appears; the count itself is checked.
  task automatic wait_for(input logic [2:0] st, input int budget, input int exp_cycles,
                          input string name);
    int n;
    n = 0;
    while (dbg_state !== st && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n != exp_cycles) begin
      bad++;
      $display("FAIL %s: reached state %0d after %0d cycles, expected %0d cycles", name, st, n, exp_cycles);
    end
  endtask

  initial begin
    // reset (first edge already has rst=1) then release with player1 serving
    add(1, 0, 0, 0, 0, S_LOAD,   X1, 2);
    add(0, 0, 0, 0, 0, S_LOAD,   X1, 1);
    // 12 HOLD cycles; point, first_touch and serve_side changes all ignored
    add(0, 0, 0, 0, 0, S_HOLD,   X1, 3);
    add(0, 1, 0, 0, 0, S_HOLD,   X1, 1);
    add(0, 0, 0, 0, 1, S_HOLD,   X1, 2);
    add(0, 0, 1, 0, 0, S_HOLD,   X1, 6);
    // SERVE: point ignored, touch starts the rally
    add(0, 1, 1, 0, 0, S_SERVE,  X1, 1);
    add(0, 0, 1, 0, 0, S_SERVE,  X1, 2);
    add(0, 0, 1, 0, 1, S_SERVE,  X1, 1);
    add(0, 0, 1, 0, 1, S_RALLY,  X1, 1);
    add(0, 0, 1, 0, 0, S_RALLY,  X1, 2);
    add(0, 1, 1, 0, 0, S_RALLY,  X1, 1);
    // FREEZE 8 cycles, then LOAD latches player2 spot
    add(0, 0, 1, 0, 1, S_FREEZE, X1, 1);
    add(0, 0, 1, 0, 0, S_FREEZE, X1, 7);
    add(0, 0, 0, 0, 0, S_LOAD,   X2, 1);
    add(0, 0, 0, 0, 0, S_HOLD,   X2, 12);
    add(0, 0, 0, 0, 0, S_SERVE,  X2, 1);
    add(0, 0, 0, 0, 1, S_SERVE,  X2, 1);
    add(0, 0, 0, 1, 0, S_RALLY,  X2, 1);
    // OVER is terminal
    add(0, 1, 0, 0, 1, S_OVER,   X2, 2);
    add(0, 0, 0, 0, 0, S_OVER,   X2, 2);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].point, vecs[i].side, vecs[i].eg, vecs[i].touch,
           vecs[i].st, vecs[i].x, $sformatf("row%0d", i));
    end

    // reset out of OVER: x returns to player1 spot even with serve_side=1
    step(1, 0, 1, 0, 0, S_OVER,  X2, "rst_from_over");
    step(0, 0, 1, 0, 0, S_LOAD,  X1, "load_after_over");
    wait_for(S_SERVE, 40, 13, "hold_len_after_over");

    // point and touch together in SERVE: rally starts, point dropped
    step(0, 1, 1, 0, 1, S_SERVE, X1, "serve_point_touch");
    step(0, 0, 1, 0, 0, S_RALLY, X1, "rally_after_both");
    step(0, 0, 1, 0, 0, S_RALLY, X1, "point_dropped");
    step(0, 1, 1, 0, 0, S_RALLY, X1, "rally_point2");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, S_FREEZE, X1, $sformatf("freeze%0d", i));

    // reset mid-FREEZE: LOAD, no load pulse while rst held, fresh HOLD length
    step(1, 0, 1, 0, 0, S_FREEZE, X1, "rst_mid_freeze");
    step(1, 0, 1, 0, 0, S_LOAD,   X1, "rst_held_no_load");
    step(0, 0, 1, 0, 0, S_LOAD,   X1, "load_after_rst");
    wait_for(S_SERVE, 40, 13, "hold_len_after_rst");

    // endgame beats first_touch in SERVE
    step(0, 0, 1, 1, 1, S_SERVE, X1, "eg_vs_touch");
    step(0, 0, 1, 0, 0, S_OVER,  X1, "over_not_rally");

    // endgame during LOAD
    step(1, 0, 0, 0, 0, S_OVER,  X1, "rst_again");
    step(0, 0, 0, 1, 0, S_LOAD,  X1, "eg_in_load");
    step(0, 0, 0, 0, 0, S_OVER,  X1, "over_from_load");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
